// File: rtl/dlx_pkg.sv
// Shared DLX integer-pipeline definitions: ALU opcodes, register constants,
// issue-stage FSM encoding and the ID/EX register layout.
package dlx_pkg;

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SGE  = 5'd9;
  localparam logic [4:0] OP_ADDF = 5'd15;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FPBUSY = 1'b1;

  // An all-zero value of this struct is a pipeline bubble.
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        is_load;
    logic        use_imm;
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } ex_reg_t;

endpackage

// File: rtl/fwd_mux.sv
// Two-source priority forwarding select: EX/MEM beats MEM/WB beats the
// register-file value; r0 is never forwarded.
module fwd_mux
  import dlx_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [31:0] rf_val,
  input  logic        exm_wen,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_wen,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic [31:0] val
);

  always_comb begin
    val = rf_val;
    if (idx != REG_ZERO) begin
      if (exm_wen && (exm_rd == idx)) begin
        val = exm_result;
      end else if (mwb_wen && (mwb_rd == idx)) begin
        val = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX register with operand forwarding, load-use bubble and branch flush.
// Define FP_STALL_EN to hold EX for FP_LAT cycles on Addf.
module id_ex_issue
  import dlx_pkg::*;
#(
  parameter int unsigned FP_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_uses_rt,
  input  logic        id_is_load,
  input  logic        id_wen,
  input  logic        flush,
  input  logic        exm_wen,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_wen,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic        id_stall,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        ex_valid,
  output logic        ex_wen,
  output logic        ex_is_load,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        ex_adv
);

  ex_reg_t     ex_q, ex_d, id_fields;
  logic [31:0] fwd_a, fwd_b, b_sel;
  logic        hazard, advance;

  fwd_mux u_fwd_rs (
    .idx        (ex_q.rs),
    .rf_val     (ex_q.rs_val),
    .exm_wen    (exm_wen),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .mwb_wen    (mwb_wen),
    .mwb_rd     (mwb_rd),
    .mwb_result (mwb_result),
    .val        (fwd_a)
  );

  fwd_mux u_fwd_rt (
    .idx        (ex_q.rt),
    .rf_val     (ex_q.rt_val),
    .exm_wen    (exm_wen),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .mwb_wen    (mwb_wen),
    .mwb_rd     (mwb_rd),
    .mwb_result (mwb_result),
    .val        (fwd_b)
  );

  assign b_sel = ex_q.use_imm ? ex_q.imm : fwd_b;

  assign hazard = ex_q.valid && ex_q.is_load && (ex_q.rd != REG_ZERO) && id_valid &&
                  ((id_rs == ex_q.rd) || (id_uses_rt && (id_rt == ex_q.rd)));

  always_comb begin
    id_fields         = '0;
    id_fields.valid   = id_valid;
    id_fields.wen     = id_wen;
    id_fields.is_load = id_is_load;
    id_fields.use_imm = id_use_imm;
    id_fields.op      = id_op;
    id_fields.rs      = id_rs;
    id_fields.rt      = id_rt;
    id_fields.rd      = id_rd;
    id_fields.rs_val  = id_rs_val;
    id_fields.rt_val  = id_rt_val;
    id_fields.imm     = id_imm;
  end

  always_comb begin
    ex_d     = ex_q;
    id_stall = 1'b0;
    if (flush) begin
      ex_d = '0;
    end else if (!advance) begin
      id_stall = 1'b1;
    end else if (hazard) begin
      ex_d     = '0;
      id_stall = 1'b1;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef FP_STALL_EN
  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hold_a_q, hold_b_q;
  logic        busy, first, last, use_hold;

  // cnt counts the remaining EX cycles after the current one.
  assign busy     = (state_q == ST_FPBUSY);
  assign first    = busy && (cnt_q == 8'(FP_LAT - 1));
  assign last     = busy && (cnt_q == 8'd0);
  assign advance  = !busy || last;
  assign use_hold = busy && !first;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush || (advance && hazard)) begin
      state_d = ST_RUN;
      cnt_d   = 8'd0;
    end else if (!advance) begin
      cnt_d = cnt_q - 8'd1;
    end else if (id_valid && (id_op == OP_ADDF)) begin
      state_d = ST_FPBUSY;
      cnt_d   = 8'(FP_LAT - 1);
    end else begin
      state_d = ST_RUN;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= 8'd0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (first) begin
        hold_a_q <= fwd_a;
        hold_b_q <= b_sel;
      end
    end
  end

  assign alu_a  = use_hold ? hold_a_q : fwd_a;
  assign alu_b  = use_hold ? hold_b_q : b_sel;
  assign ex_adv = advance;
`else
  logic unused_fp_lat;
  assign unused_fp_lat = ^FP_LAT;
  assign advance       = 1'b1;
  assign alu_a         = fwd_a;
  assign alu_b         = b_sel;
  assign ex_adv        = 1'b1;
`endif

  assign alu_op        = ex_q.op;
  assign ex_valid      = ex_q.valid;
  assign ex_wen        = ex_q.wen && ex_q.valid;
  assign ex_is_load    = ex_q.is_load;
  assign ex_rd         = ex_q.rd;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed self-checking bench for id_ex_issue; FP_STALL_EN selects the
// multi-cycle Addf checks, otherwise Addf is checked as single-cycle.
module tb_id_ex_issue;

  logic        clk, rst;
  logic        id_valid, id_use_imm, id_uses_rt, id_is_load, id_wen, flush;
  logic [4:0]  id_op, id_rs, id_rt, id_rd;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        id_stall, ex_valid, ex_wen, ex_is_load, ex_adv;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  alu_op, ex_rd;

  int checks = 0;
  int failures = 0;

  id_ex_issue #(.FP_LAT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_op         (id_op),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_val     (id_rs_val),
    .id_rt_val     (id_rt_val),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_uses_rt    (id_uses_rt),
    .id_is_load    (id_is_load),
    .id_wen        (id_wen),
    .flush         (flush),
    .exm_wen       (exm_wen),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_wen       (mwb_wen),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .id_stall      (id_stall),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_wen        (ex_wen),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .ex_store_data (ex_store_data),
    .ex_adv        (ex_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_id();
    id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_use_imm = 0; id_uses_rt = 0; id_is_load = 0; id_wen = 0;
  endtask

  task automatic clr_fwd();
    exm_wen = 0; exm_rd = 0; exm_result = 0;
    mwb_wen = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv);
    clr_id();
    id_valid = 1; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_uses_rt = 1; id_wen = 1;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clr_id();
    id_valid = 1; id_op = 5'd2; id_rs = 5'd1; id_rs_val = 32'h100;
    id_use_imm = 1; id_imm = 32'h4; id_is_load = 1; id_wen = 1; id_rd = rd;
  endtask

  initial begin
    rst = 1; flush = 0;
    clr_id();
    clr_fwd();
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_wen", 32'(ex_wen), 32'h0);
    chk("rst_ex_is_load", 32'(ex_is_load), 32'h0);
    chk("rst_ex_rd", 32'(ex_rd), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_store", ex_store_data, 32'h0);
    chk("rst_id_stall", 32'(id_stall), 32'h0);
    chk("rst_ex_adv", 32'(ex_adv), 32'h1);
    @(negedge clk);
    rst = 0;

    // Forwarding priority on rs, then rt forwarding into B and store data.
    drive_alu(5'd2, 5'd3, 5'd7, 5'd8, 32'h111, 32'h222);
    step();
    exm_wen = 1; exm_rd = 5'd3; exm_result = 32'h5;
    mwb_wen = 1; mwb_rd = 5'd3; mwb_result = 32'h9;
    #1;
    chk("fwd_exm_wins", alu_a, 32'h5);
    chk("fwd_rt_none", alu_b, 32'h222);
    chk("cap_alu_op", 32'(alu_op), 32'h2);
    chk("cap_ex_rd", 32'(ex_rd), 32'h8);
    chk("cap_ex_wen", 32'(ex_wen), 32'h1);
    exm_wen = 0;
    #1;
    chk("fwd_mwb", alu_a, 32'h9);
    mwb_wen = 0;
    #1;
    chk("fwd_none", alu_a, 32'h111);
    exm_wen = 1; exm_rd = 5'd7; exm_result = 32'h77;
    #1;
    chk("fwd_rt_b", alu_b, 32'h77);
    chk("fwd_rt_store", ex_store_data, 32'h77);

    // r0 is never forwarded; immediate selects B while store data keeps rt.
    clr_id();
    id_valid = 1; id_op = 5'd1; id_rs = 5'd0; id_rs_val = 32'hABC;
    id_rt = 5'd0; id_rt_val = 32'h55; id_use_imm = 1; id_imm = 32'h10;
    step();
    exm_wen = 1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    mwb_wen = 1; mwb_rd = 5'd0; mwb_result = 32'hBEEF;
    #1;
    chk("r0_alu_a", alu_a, 32'hABC);
    chk("imm_alu_b", alu_b, 32'h10);
    chk("r0_store", ex_store_data, 32'h55);
    clr_fwd();

    // Load r4 then add r5,r4,r6: one bubble, then MEM/WB forwarding.
    drive_load(5'd4);
    step();
    drive_alu(5'd2, 5'd4, 5'd6, 5'd5, 32'h0, 32'h6);
    #1;
    chk("lu_stall", 32'(id_stall), 32'h1);
    chk("lu_ex_is_load", 32'(ex_is_load), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_wen", 32'(ex_wen), 32'h0);
    chk("lu_stall_once", 32'(id_stall), 32'h0);
    step();
    mwb_wen = 1; mwb_rd = 5'd4; mwb_result = 32'h3FF;
    #1;
    chk("lu_mwb_a", alu_a, 32'h3FF);
    chk("lu_b", alu_b, 32'h6);
    chk("lu_ex_rd", 32'(ex_rd), 32'h5);
    clr_fwd();

    // Flush together with a load-use hazard: flush wins, no stall.
    drive_load(5'd4);
    step();
    drive_alu(5'd2, 5'd4, 5'd6, 5'd5, 32'h0, 32'h6);
    flush = 1;
    #1;
    chk("fl_stall", 32'(id_stall), 32'h0);
    step();
    flush = 0;
    chk("fl_ex_valid", 32'(ex_valid), 32'h0);
    chk("fl_ex_wen", 32'(ex_wen), 32'h0);
    chk("fl_alu_op", 32'(alu_op), 32'h0);
    chk("fl_ex_rd", 32'(ex_rd), 32'h0);
    clr_id();

    // Addf 41700000 + 43700000 (r1 + r2).
    drive_alu(5'd15, 5'd1, 5'd2, 5'd3, 32'h41700000, 32'h43700000);
    step();
    drive_alu(5'd2, 5'd10, 5'd11, 5'd12, 32'h1, 32'h2);
    #1;
    chk("fp_c1_op", 32'(alu_op), 32'hF);
    chk("fp_c1_a", alu_a, 32'h41700000);
    chk("fp_c1_b", alu_b, 32'h43700000);
`ifdef FP_STALL_EN
    chk("fp_c1_stall", 32'(id_stall), 32'h1);
    chk("fp_c1_adv", 32'(ex_adv), 32'h0);
    step();
    exm_wen = 1; exm_rd = 5'd1; exm_result = 32'h12345678;
    mwb_wen = 1; mwb_rd = 5'd2; mwb_result = 32'h87654321;
    #1;
    chk("fp_c2_stall", 32'(id_stall), 32'h1);
    chk("fp_c2_adv", 32'(ex_adv), 32'h0);
    chk("fp_c2_hold_a", alu_a, 32'h41700000);
    chk("fp_c2_hold_b", alu_b, 32'h43700000);
    step();
    exm_result = 32'hCAFE;
    #1;
    chk("fp_c3_stall", 32'(id_stall), 32'h0);
    chk("fp_c3_adv", 32'(ex_adv), 32'h1);
    chk("fp_c3_hold_a", alu_a, 32'h41700000);
    clr_fwd();
    step();
    chk("fp_next_op", 32'(alu_op), 32'h2);
    chk("fp_next_adv", 32'(ex_adv), 32'h1);

    // Reset in the middle of FPBUSY, then a fresh Addf takes three cycles again.
    drive_alu(5'd15, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    step();
    #1;
    chk("fr_busy_stall", 32'(id_stall), 32'h1);
    rst = 1;
    #1;
    chk("fr_ex_valid", 32'(ex_valid), 32'h0);
    chk("fr_id_stall", 32'(id_stall), 32'h0);
    chk("fr_ex_adv", 32'(ex_adv), 32'h1);
    rst = 0;
    step();
    drive_alu(5'd2, 5'd10, 5'd11, 5'd12, 32'h1, 32'h2);
    #1;
    chk("fr2_c1_stall", 32'(id_stall), 32'h1);
    step();
    chk("fr2_c2_stall", 32'(id_stall), 32'h1);
    step();
    chk("fr2_c3_stall", 32'(id_stall), 32'h0);
    chk("fr2_c3_adv", 32'(ex_adv), 32'h1);
`else
    chk("fp_single_stall", 32'(id_stall), 32'h0);
    chk("fp_single_adv", 32'(ex_adv), 32'h1);
    step();
    chk("fp_single_next_op", 32'(alu_op), 32'h2);
    chk("fp_single_next_a", alu_a, 32'h1);
`endif
    clr_id();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
